// File: rtl/dma_channel_scheduler.sv
// Round-robin front end for the single-engine DMA master: arbitrates channel requests,
// loads the engine, triggers it, and waits for completion with a hang watchdog.
module dma_channel_scheduler #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     req,
    input  logic [32*NUM_CH-1:0]  ch_src,
    input  logic [32*NUM_CH-1:0]  ch_dst,
    input  logic [5*NUM_CH-1:0]   ch_len,
    output logic [NUM_CH-1:0]     grant,
    output logic [NUM_CH-1:0]     ch_done,
    output logic [NUM_CH-1:0]     ch_err,
    output logic                  dma_trigger,
    output logic [31:0]           dma_src,
    output logic [31:0]           dma_dst,
    output logic [4:0]            dma_len,
    input  logic                  dma_done,
    output logic                  busy,
    output logic                  hung
);

    localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TRIG,
        S_WAIT,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic [NUM_CH-1:0]   err_q, err_d;
    logic                trig_q, trig_d;
    logic [31:0]         src_q, src_d;
    logic [31:0]         dst_q, dst_d;
    logic [4:0]          len_q, len_d;
    logic                busy_q, busy_d;
    logic                hung_q, hung_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;

    logic                found;
    logic [IDX_W-1:0]    win;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    nxt_ptr;
    logic [4:0]          win_len;
    logic                len_ok;
    logic [WDOG_W-1:0]   wdog_inc;

    // Round-robin pick starting at ptr_q, plus the winner's length check.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % NUM_CH);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        nxt_ptr = (win == IDX_W'(NUM_CH - 1)) ? '0 : win + IDX_W'(1);
        win_len = ch_len[5*32'(win) +: 5];
        len_ok  = (win_len[1:0] == 2'b00) && (win_len[4:2] != 3'b000);
    end

    assign wdog_inc = wdog_q + WDOG_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            trig_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            hung_q  <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            trig_q  <= trig_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            hung_q  <= hung_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        trig_d  = 1'b0;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        hung_d  = hung_q;
        wdog_d  = wdog_q;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    ptr_d = nxt_ptr;
                    if (len_ok) begin
                        // Engine buses and grant become valid on the arbitration edge.
                        state_d = S_LOAD;
                        sel_d   = win;
                        grant_d = NUM_CH'(1) << win;
                        src_d   = ch_src[32*32'(win) +: 32];
                        dst_d   = ch_dst[32*32'(win) +: 32];
                        len_d   = win_len;
                    end else begin
                        err_d[win] = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                trig_d  = 1'b1;
                state_d = S_TRIG;
            end
            S_TRIG: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_inc;
                // A done seen on the same edge as expiry still completes the transfer.
                if (dma_done) begin
                    done_d[sel_q] = 1'b1;
                    state_d       = S_DRAIN;
                end else if (wdog_inc == WDOG_W'(TIMEOUT)) begin
                    err_d[sel_q] = 1'b1;
                    hung_d       = 1'b1;
                    state_d      = S_HALT;
                end
            end
            S_DRAIN: begin
                if (!dma_done) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign grant       = grant_q;
    assign ch_done     = done_q;
    assign ch_err      = err_q;
    assign dma_trigger = trig_q;
    assign dma_src     = src_q;
    assign dma_dst     = dst_q;
    assign dma_len     = len_q;
    assign busy        = busy_q;
    assign hung        = hung_q;

endmodule

// File: doc/dma_channel_scheduler.md
# dma_channel_scheduler

Multi-channel front end for the single-engine DMA master. It accepts transfer requests from `NUM_CH` independent channels and picks one round-robin. It loads that channel's source, destination and length into the engine, fires a one-cycle trigger, and waits for the engine's done before serving the next channel. It also rejects malformed lengths and detects a hung engine with a watchdog.

## Interface
Parameters:
- `NUM_CH`, 4: number of requesting channels (2..8).
- `TIMEOUT`, 1023: cycles allowed in WAIT before a hang is declared; counter width is clog2(TIMEOUT+1).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset. Synchronous, active-high; clock `clk`.
- `req`, in, NUM_CH: per-channel request level; held until that channel's `ch_done` or `ch_err` pulse.
- `ch_src`, in, 32*NUM_CH: source byte address, channel i at bits [32i+31:32i].
- `ch_dst`, in, 32*NUM_CH: destination byte address, same packing.
- `ch_len`, in, 5*NUM_CH: byte length, same packing (5 bits per channel).
- `grant`, out, NUM_CH: one-hot; the channel currently owning the engine.
- `ch_done`, out, NUM_CH: one-cycle pulse on successful completion.
- `ch_err`, out, NUM_CH: one-cycle pulse on length rejection or timeout.
- `dma_trigger`, out, 1: one-cycle start pulse to the engine.
- `dma_src`, out, 32: registered source address to the engine.
- `dma_dst`, out, 32: registered destination address to the engine.
- `dma_len`, out, 5: registered length to the engine.
- `dma_done`, in, 1: engine completion; may be a pulse or a level.
- `busy`, out, 1: high in any state other than IDLE.
- `hung`, out, 1: sticky; set on timeout, cleared only by reset.

## Operation
States: IDLE, LOAD, TRIG, WAIT, DRAIN, HALT.

- **IDLE.** Round-robin search begins at `ptr`, then `ptr+1`, and so on modulo NUM_CH, taking the first asserted `req`.
  - If the winner's length is valid, go to LOAD.
  - If the length is invalid, pulse that channel's `ch_err` and stay in IDLE.
  - In both cases `ptr` becomes winner+1 (wrapping NUM_CH-1 to 0).
- **Length validity.** Valid means `len[1:0]==0` and `len>=4`. So 4, 8, …, 28 are accepted; 0, 1..3 and non-multiples of 4 are rejected.
- **LOAD.** Register `dma_src`, `dma_dst`, `dma_len` and the one-hot `grant` for the winner, then go to TRIG.
- **TRIG.** `dma_trigger`=1 for this cycle only. Clear the watchdog and go to WAIT.
- **WAIT.** The watchdog increments each cycle.
  - On `dma_done`=1: pulse `ch_done[winner]`, go to DRAIN.
  - On watchdog==TIMEOUT: pulse `ch_err[winner]`, set `hung`, go to HALT.
  - If both happen in the same cycle, `dma_done` wins.
- **DRAIN.** Wait for `dma_done`=0, then deassert `grant` and return to IDLE. This tolerates an engine that holds done high until its trigger latch clears.
- **HALT.** Terminal state, left only by reset. `grant` is held, `busy`=1, and no further triggers are issued.
- **Request changes mid-service.** A `req` deasserted after LOAD does not abort the transfer; the transfer completes normally. A `req` re-asserted by the just-served channel loses to every other pending channel on the next arbitration.
- **Reset mid-operation.** Go to IDLE and set `ptr`=0. All outputs return to reset values immediately after the reset edge. An in-flight engine transfer is not tracked; the engine is reset by the same signal.

## Timing
- **Reset values.** `grant`=0, `ch_done`=0, `ch_err`=0, `dma_trigger`=0, `dma_src`=0, `dma_dst`=0, `dma_len`=0, `busy`=0, `hung`=0, `ptr`=0, state IDLE.
- **All outputs are registered.** No combinational path exists from any input to any output.
- **Request to start.** `req` is sampled at edge E0 in IDLE.
  - After E0: `grant` and the `dma_*` buses are valid.
  - After E1: `dma_trigger`=1.
  - After E2: `dma_trigger`=0, state WAIT.
  - The `dma_*` buses are stable at least one cycle before `trigger` and stay stable until DRAIN exits.
- **Completion.** `dma_done` is sampled at edge En in WAIT. `ch_done` is high for the cycle after En.
  - If `dma_done` is a one-cycle pulse: DRAIN passes in one cycle, and the next arbitration occurs at En+2.
  - Back-to-back throughput is therefore 4 cycles of scheduler overhead plus engine time per transfer.
- **Rejection.** `ch_err` pulses the cycle after the sampling edge. The next arbitration can occur on the very next edge.
- **Output hold.** `grant` is one-hot or zero at all times. `ch_done` and `ch_err` are never high together for the same channel.

## Test plan
- **Single transfer.** After reset, `req`=0001, ch0 src=0x1000, dst=0x2000, len=16.
  - Required: `grant`=0001 at cycle+1, one `dma_trigger` at cycle+2 with `dma_src`=0x1000, `dma_dst`=0x2000, `dma_len`=16.
  - Drive a `dma_done` pulse 20 cycles later. Required: `ch_done`=0001 for one cycle, then `busy`=0.
- **Round-robin fairness.** Hold `req`=1111 continuously; the engine model returns done 5 cycles after each trigger.
  - Required: grant order ch0, ch1, ch2, ch3, ch0; each channel is served once per 4 transfers.
- **Length rejection.** Set ch1 len=6 and ch2 len=0 with `req`=0110.
  - Required: `ch_err`=0010, then `ch_err`=0100, on consecutive cycles. No `dma_trigger` is issued and `ptr` ends at 3.
- **Level done.** The engine holds `dma_done` high for 7 cycles.
  - Required: exactly one `ch_done` pulse, and no new `grant` until the cycle after `dma_done` falls.
- **Timeout.** With TIMEOUT=15, trigger ch3 and never assert done.
  - Required: `ch_err`=1000 and `hung`=1 exactly 16 cycles after trigger. No further triggers while other `req` bits are pending. Reset clears `hung` and `busy`.
- **Reset in WAIT.** Assert `reset` during WAIT.
  - Required: all outputs return to their reset values right after the reset edge. The first arbitration after reset starts at ch0.
